// File: rtl/rbm_sample_sequencer.sv
// Host-side sequencer for the RBM inference engine.
// It loads one sample word by word, resets and launches the engine, and waits
// for finish (or a timeout). It then reduces the output vector to a signed
// argmax and hands the class and score over a valid/ready handshake.

// One input word of the packed sample. It is written only while the sample loads.
module rbm_word_reg #(
    parameter int bitlength = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we,
    input  logic [bitlength-1:0] d,
    output logic [bitlength-1:0] q
);
    // Capture the word on its write strobe; it holds for the rest of the sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset)   q <= '0;
        else if (we) q <= d;
    end
endmodule

module rbm_sample_sequencer #(
    parameter int bitlength         = 12,
    parameter int general_input_dim = 15,
    parameter int output_dim        = 2,
    parameter int class_width       = 1,
    parameter int reset_cycles      = 2,
    parameter int timeout_cycles    = 65535
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [bitlength-1:0]                   s_data,
    output logic                                   eng_reset,
    output logic                                   eng_data_valid,
    output logic [general_input_dim*bitlength-1:0] eng_input,
    input  logic [output_dim*bitlength-1:0]        eng_output,
    input  logic                                   eng_finish,
    output logic                                   r_valid,
    input  logic                                   r_ready,
    output logic [class_width-1:0]                 r_class,
    output logic [bitlength-1:0]                   r_score,
    output logic                                   r_timeout,
    output logic [15:0]                            sample_count
);
    localparam int WIW = (general_input_dim > 1) ? $clog2(general_input_dim) : 1;
    localparam int RCW = (reset_cycles > 1)      ? $clog2(reset_cycles)      : 1;
    localparam int TCW = (timeout_cycles > 1)    ? $clog2(timeout_cycles)    : 1;
    localparam int AW  = (output_dim > 1)        ? $clog2(output_dim)        : 1;

    typedef enum logic [2:0] {LOAD, RESET_ENG, SETTLE, RUN, ARGMAX, RESULT} state_t;

    state_t                               state;
    logic [WIW-1:0]                       wr_idx;
    logic [RCW-1:0]                       rst_cnt;
    logic [TCW-1:0]                       run_cnt;
    logic [AW-1:0]                        arg_idx;
    logic [output_dim-1:0][bitlength-1:0] out_reg;
    logic signed [bitlength-1:0]          best;
    logic [AW-1:0]                        best_idx;
    logic                                 load_fire;
    logic [general_input_dim-1:0][bitlength-1:0] in_words;

    assign load_fire = s_valid & s_ready;
    assign eng_input = in_words;

    // One register per input word; s_ready is only high in LOAD, so the
    // sample is frozen for the whole run.
    for (genvar i = 0; i < general_input_dim; i++) begin : g_word
        rbm_word_reg #(.bitlength(bitlength)) u_word (
            .clock (clock),
            .reset (reset),
            .we    (load_fire && (wr_idx == WIW'(i))),
            .d     (s_data),
            .q     (in_words[i])
        );
    end

    // Argmax step: element 0 always seeds, and later elements win only on
    // strictly greater, so ties keep the lowest index.
    logic signed [bitlength-1:0] cand;
    logic signed [bitlength-1:0] next_best;
    logic [AW-1:0]               next_idx;
    logic                        take;
    always_comb begin
        cand      = out_reg[arg_idx];
        take      = (arg_idx == '0) || (cand > best);
        next_best = take ? cand : best;
        next_idx  = take ? arg_idx : best_idx;
    end

    // Sequencer FSM with registered handshake and engine-control outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= LOAD;
            s_ready        <= 1'b1;
            eng_reset      <= 1'b1;
            eng_data_valid <= 1'b0;
            r_valid        <= 1'b0;
            r_class        <= '0;
            r_score        <= '0;
            r_timeout      <= 1'b0;
            sample_count   <= '0;
            wr_idx         <= '0;
            rst_cnt        <= '0;
            run_cnt        <= '0;
            arg_idx        <= '0;
            out_reg        <= '0;
            best           <= '0;
            best_idx       <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        if (wr_idx == WIW'(general_input_dim - 1)) begin
                            wr_idx  <= '0;
                            rst_cnt <= '0;
                            s_ready <= 1'b0;
                            state   <= RESET_ENG;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                RESET_ENG: begin
                    if (rst_cnt == RCW'(reset_cycles - 1)) begin
                        rst_cnt   <= '0;
                        eng_reset <= 1'b0;
                        state     <= SETTLE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    // One quiet cycle so the engine sees reset fall before data_valid
                    run_cnt        <= '0;
                    eng_data_valid <= 1'b1;
                    state          <= RUN;
                end
                RUN: begin
                    if (eng_finish || (run_cnt == TCW'(timeout_cycles - 1))) begin
                        out_reg        <= eng_output;
                        r_timeout      <= ~eng_finish;
                        eng_data_valid <= 1'b0;
                        arg_idx        <= '0;
                        state          <= ARGMAX;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                ARGMAX: begin
                    best     <= next_best;
                    best_idx <= next_idx;
                    if (arg_idx == AW'(output_dim - 1)) begin
                        r_class <= class_width'(next_idx);
                        r_score <= next_best;
                        r_valid <= 1'b1;
                        arg_idx <= '0;
                        state   <= RESULT;
                    end else begin
                        arg_idx <= arg_idx + 1'b1;
                    end
                end
                RESULT: begin
                    // Returning to LOAD raises eng_reset, so the engine's sticky
                    // finish is cleared before the next launch
                    if (r_ready) begin
                        r_valid      <= 1'b0;
                        sample_count <= sample_count + 1'b1;
                        s_ready      <= 1'b1;
                        eng_reset    <= 1'b1;
                        state        <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_rbm_sample_sequencer.sv
// Directed bench for rbm_sample_sequencer with a small engine model:
// finish rises after a programmable number of data_valid cycles and stays
// high until eng_reset.
module tb_rbm_sample_sequencer;
    localparam int BL  = 12;
    localparam int DIM = 15;
    localparam int OD  = 2;
    localparam int CW  = 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              s_valid = 1'b0;
    logic [BL-1:0]     s_data = '0;
    logic              s_ready;
    logic              eng_reset, eng_data_valid;
    logic [DIM*BL-1:0] eng_input;
    logic [OD*BL-1:0]  eng_output = '0;
    logic              eng_finish = 1'b0;
    logic              r_valid;
    logic              r_ready = 1'b0;
    logic [CW-1:0]     r_class;
    logic [BL-1:0]     r_score;
    logic              r_timeout;
    logic [15:0]       sample_count;

    // second instance with a short timeout, engine never finishes
    logic              to_s_valid = 1'b0;
    logic [BL-1:0]     to_s_data = '0;
    logic              to_s_ready, to_eng_reset, to_eng_data_valid;
    logic [DIM*BL-1:0] to_eng_input;
    logic [OD*BL-1:0]  to_eng_output = {12'h3AB, 12'h1CD};
    logic              to_eng_finish = 1'b0;
    logic              to_r_valid;
    logic              to_r_ready = 1'b0;
    logic [CW-1:0]     to_r_class;
    logic [BL-1:0]     to_r_score;
    logic              to_r_timeout;
    logic [15:0]       to_sample_count;

    rbm_sample_sequencer dut (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .eng_reset(eng_reset), .eng_data_valid(eng_data_valid), .eng_input(eng_input),
        .eng_output(eng_output), .eng_finish(eng_finish), .r_valid(r_valid), .r_ready(r_ready),
        .r_class(r_class), .r_score(r_score), .r_timeout(r_timeout), .sample_count(sample_count)
    );

    rbm_sample_sequencer #(.timeout_cycles(8)) dut_to (
        .clock(clock), .reset(reset), .s_valid(to_s_valid), .s_ready(to_s_ready), .s_data(to_s_data),
        .eng_reset(to_eng_reset), .eng_data_valid(to_eng_data_valid), .eng_input(to_eng_input),
        .eng_output(to_eng_output), .eng_finish(to_eng_finish), .r_valid(to_r_valid),
        .r_ready(to_r_ready), .r_class(to_r_class), .r_score(to_r_score),
        .r_timeout(to_r_timeout), .sample_count(to_sample_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // engine model: fin_delay = 0 means it never finishes
    int fin_delay = 0;
    int e_cnt = 0;
    always @(posedge clock) begin
        if (eng_reset) begin
            e_cnt      <= 0;
            eng_finish <= 1'b0;
        end else if (eng_data_valid) begin
            e_cnt <= e_cnt + 1;
            if (fin_delay != 0 && e_cnt + 1 == fin_delay) eng_finish <= 1'b1;
        end
    end

    // count eng_reset rising edges
    int   rst_rises = 0;
    logic rst_prev = 1'b1;
    always @(negedge clock) begin
        if (eng_reset && !rst_prev) rst_rises <= rst_rises + 1;
        rst_prev <= eng_reset;
    end

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    logic [BL-1:0] smp [DIM];
    int          acc_cyc = 0;

    task automatic load_sample(input bit gappy, output bit rst_held);
        int  i = 0;
        bit  ph = 1'b0;
        rst_held = 1'b1;
        for (int g = 0; g < 200 && i < DIM; g++) begin
            @(negedge clock);
            if (eng_reset !== 1'b1) rst_held = 1'b0;
            s_valid = gappy ? ph : 1'b1;
            ph      = ~ph;
            s_data  = smp[i];
            if (s_valid && s_ready) begin
                acc_cyc = cyc;
                i++;
            end
        end
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int rst_fall, output int dv_rise,
                               output logic fin_at_dv, output bit ok);
        lat = -1; rst_fall = -1; dv_rise = -1; fin_at_dv = 1'bx; ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (rst_fall < 0 && !eng_reset) rst_fall = cyc - acc_cyc;
            if (dv_rise < 0 && eng_data_valid) begin
                dv_rise   = cyc - acc_cyc;
                fin_at_dv = eng_finish;
            end
            if (r_valid) begin
                lat = cyc - acc_cyc;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept_result();
        @(negedge clock);
        r_ready = 1'b1;
        @(negedge clock);
        r_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++; if (eng_reset !== 1'b1) begin errors++; $display("FAIL reset_eng_reset: got %b expected 1", eng_reset); end
        checks++; if (eng_data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", eng_data_valid); end
        checks++; if (r_valid !== 1'b0 || r_timeout !== 1'b0) begin errors++; $display("FAIL reset_rvalid_timeout: got %b%b expected 00", r_valid, r_timeout); end
        checks++; if (r_class !== '0 || r_score !== '0) begin errors++; $display("FAIL reset_result: got class %h score %h expected 0 0", r_class, r_score); end
        checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", sample_count); end
        checks++; if (eng_input !== '0) begin errors++; $display("FAIL reset_eng_input: got %h expected 0", eng_input); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, rf, dr; logic fd; bit ok, held;
        logic [DIM*BL-1:0] exp_in;
        for (int i = 0; i < DIM; i++) smp[i] = BL'(i + 1);
        for (int i = 0; i < DIM; i++) exp_in[i*BL +: BL] = smp[i];
        fin_delay  = 10;
        eng_output = {12'h120, 12'h050};
        load_sample(1'b0, held);
        wait_result(lat, rf, dr, fd, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_result_timeout: no r_valid within 300 cycles"); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency: got %0d expected 17", lat); end
        checks++; if (r_class !== 1'b1 || r_score !== 12'h120) begin errors++; $display("FAIL basic_argmax: got class %h score %h expected 1 120", r_class, r_score); end
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout_flag: got %b expected 0", r_timeout); end
        checks++; if (eng_input[14*BL +: BL] !== 12'h00F) begin errors++; $display("FAIL basic_elem14: got %h expected 00f", eng_input[14*BL +: BL]); end
        checks++; if (eng_input !== exp_in) begin errors++; $display("FAIL basic_eng_input: got %h expected %h", eng_input, exp_in); end
        accept_result();
        checks++; if (sample_count !== exp_cnt || s_ready !== 1'b1) begin errors++; $display("FAIL basic_count: got %0d ready %b expected %0d ready 1", sample_count, s_ready, exp_cnt); end
    endtask

    task automatic test_signed();
        int lat, rf, dr; logic fd; bit ok, held;
        logic [BL-1:0] o0 [3];
        logic [BL-1:0] o1 [3];
        logic [CW-1:0] ec [3];
        logic [BL-1:0] es [3];
        o0[0] = 12'hF00; o1[0] = 12'hE00; ec[0] = 1'b0; es[0] = 12'hF00;
        o0[1] = 12'h7FF; o1[1] = 12'h7FF; ec[1] = 1'b0; es[1] = 12'h7FF;
        o0[2] = 12'h800; o1[2] = 12'h7FF; ec[2] = 1'b1; es[2] = 12'h7FF;
        fin_delay = 3;
        for (int t = 0; t < 3; t++) begin
            eng_output = {o1[t], o0[t]};
            load_sample(1'b0, held);
            wait_result(lat, rf, dr, fd, ok);
            checks++;
            if (!ok || r_class !== ec[t] || r_score !== es[t])
                begin errors++; $display("FAIL signed_argmax_%0d: got ok %b class %h score %h expected class %h score %h", t, ok, r_class, r_score, ec[t], es[t]); end
            accept_result();
        end
    endtask

    task automatic test_gappy();
        int lat, rf, dr; logic fd; bit ok, held;
        logic [DIM*BL-1:0] exp_in;
        for (int i = 0; i < DIM; i++) smp[i] = BL'(2048 + 37 * i);
        for (int i = 0; i < DIM; i++) exp_in[i*BL +: BL] = smp[i];
        fin_delay  = 2;
        eng_output = {12'h001, 12'h002};
        load_sample(1'b1, held);
        wait_result(lat, rf, dr, fd, ok);
        checks++; if (!held) begin errors++; $display("FAIL gappy_eng_reset_load: eng_reset dropped during LOAD"); end
        checks++; if (rf !== 3) begin errors++; $display("FAIL gappy_reset_fall: got %0d expected 3", rf); end
        checks++; if (dr !== 4) begin errors++; $display("FAIL gappy_dv_rise: got %0d expected 4", dr); end
        checks++; if (!ok || eng_input !== exp_in) begin errors++; $display("FAIL gappy_eng_input: got %h expected %h", eng_input, exp_in); end
        checks++; if (r_class !== 1'b0 || r_score !== 12'h002) begin errors++; $display("FAIL gappy_argmax: got class %h score %h expected 0 002", r_class, r_score); end
        accept_result();
    endtask

    task automatic test_back_to_back();
        int lat, rf, dr; logic fd; bit ok, held, stable;
        logic [CW-1:0] c0; logic [BL-1:0] sc0; logic [15:0] n0; int rises0;
        for (int i = 0; i < DIM; i++) smp[i] = BL'(100 + i);
        fin_delay  = 5;
        eng_output = {12'h0AA, 12'h0BB};
        load_sample(1'b0, held);
        wait_result(lat, rf, dr, fd, ok);
        c0 = r_class; sc0 = r_score; n0 = sample_count; stable = ok;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (r_valid !== 1'b1 || r_class !== c0 || r_score !== sc0 || sample_count !== n0) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL hold_stable: got valid %b class %h score %h count %0d expected 1 %h %h %0d", r_valid, r_class, r_score, sample_count, c0, sc0, n0); end
        checks++; if (c0 !== 1'b0 || sc0 !== 12'h0BB) begin errors++; $display("FAIL hold_argmax: got class %h score %h expected 0 0bb", c0, sc0); end
        checks++; if (n0 !== exp_cnt) begin errors++; $display("FAIL hold_count_before: got %0d expected %0d", n0, exp_cnt); end
        rises0 = rst_rises;
        accept_result();
        checks++; if (sample_count !== exp_cnt) begin errors++; $display("FAIL hold_count_after: got %0d expected %0d", sample_count, exp_cnt); end
        eng_output = {12'h300, 12'h2FF};
        load_sample(1'b0, held);
        wait_result(lat, rf, dr, fd, ok);
        checks++; if (rst_rises !== rises0 + 1) begin errors++; $display("FAIL b2b_reset_rise: got %0d expected %0d", rst_rises, rises0 + 1); end
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL b2b_stale_finish: got %b expected 0", fd); end
        checks++; if (!ok || r_class !== 1'b1 || r_score !== 12'h300) begin errors++; $display("FAIL b2b_argmax: got class %h score %h expected 1 300", r_class, r_score); end
        accept_result();
    endtask

    task automatic test_timeout();
        int i = 0; int a = 0; int lat = -1;
        for (int g = 0; g < 100 && i < DIM; g++) begin
            @(negedge clock);
            to_s_valid = 1'b1;
            to_s_data  = smp[i];
            if (to_s_ready) begin a = cyc; i++; end
        end
        @(negedge clock);
        to_s_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (to_r_valid) begin lat = cyc - a; break; end
        end
        checks++; if (lat !== 14) begin errors++; $display("FAIL timeout_latency: got %0d expected 14", lat); end
        checks++; if (to_r_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", to_r_timeout); end
        checks++; if (to_r_class !== 1'b1 || to_r_score !== 12'h3AB) begin errors++; $display("FAIL timeout_capture: got class %h score %h expected 1 3ab", to_r_class, to_r_score); end
    endtask

    task automatic test_reset_mid_run();
        int lat, rf, dr; logic fd; bit ok, held;
        fin_delay  = 0;
        eng_output = {12'h100, 12'h2FF};
        load_sample(1'b0, held);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (eng_data_valid) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL midrun_reach_run: eng_data_valid never rose"); end
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (eng_reset !== 1'b1 || s_ready !== 1'b1 || eng_data_valid !== 1'b0) begin errors++; $display("FAIL midrun_async_ctrl: got rst %b ready %b dv %b expected 1 1 0", eng_reset, s_ready, eng_data_valid); end
        checks++; if (r_valid !== 1'b0 || sample_count !== 16'd0 || eng_input !== '0) begin errors++; $display("FAIL midrun_async_state: got valid %b count %0d input %h expected 0 0 0", r_valid, sample_count, eng_input); end
        exp_cnt = '0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < DIM; i++) smp[i] = BL'(3 * i);
        fin_delay = 4;
        load_sample(1'b0, held);
        wait_result(lat, rf, dr, fd, ok);
        checks++; if (!ok || lat !== 11) begin errors++; $display("FAIL midrun_latency: got %0d expected 11", lat); end
        checks++; if (r_class !== 1'b0 || r_score !== 12'h2FF || r_timeout !== 1'b0) begin errors++; $display("FAIL midrun_result: got class %h score %h to %b expected 0 2ff 0", r_class, r_score, r_timeout); end
        accept_result();
        checks++; if (sample_count !== 16'd1) begin errors++; $display("FAIL midrun_count: got %0d expected 1", sample_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_gappy();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/rbm_sample_sequencer.md
# rbm_sample_sequencer

Host-side sequencer for the RBM inference engine (`hidden → classify` layer pair with iteration accumulation). It streams one input sample in word by word and packs it into the engine's flat input vector. It then resets and launches the engine, waits for the engine's `finish`, and reduces the accumulated output vector to a class index by signed argmax. The result is returned over a valid/ready handshake, and the sequencer then rearms for the next sample.

## Interface
- `bitlength`, 12, fixed-point word width; must equal the engine's value.
- `general_input_dim`, 15, number of input words per sample.
- `output_dim`, 2, number of engine output words.
- `class_width`, 1, width of `r_class`; must be ≥ ceil(log2(`output_dim`)), minimum 1.
- `reset_cycles`, 2, number of cycles `eng_reset` is held after the sample is loaded; minimum 1.
- `timeout_cycles`, 65535, maximum number of RUN cycles before the run is aborted.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  high only in LOAD.
- `s_data`  in  `bitlength`  signed input word; the first accepted word is element 0.
- `eng_reset`  out  1  engine reset.
- `eng_data_valid`  out  1  engine `data_valid`.
- `eng_input`  out  `general_input_dim*bitlength`  packed sample; element i is at bits [i*bitlength +: bitlength].
- `eng_output`  in  `output_dim*bitlength`  engine accumulated output, same packing as `eng_input`.
- `eng_finish`  in  1  engine finish; a level that stays high until the engine is reset.
- `r_valid`  out  1  result valid.
- `r_ready`  in  1  result accepted.
- `r_class`  out  `class_width`  argmax index.
- `r_score`  out  `bitlength`  winning score (signed).
- `r_timeout`  out  1  set when the result came from a timeout abort.
- `sample_count`  out  16  number of results handed off; wraps at 65535→0.

## Operation
FSM states: LOAD, RESET_ENG, SETTLE, RUN, ARGMAX, RESULT.

- **LOAD**
  - `s_ready`=1, `eng_reset`=1.
  - Each `s_valid`&`s_ready` cycle writes `s_data` into element `wr_idx`, then increments `wr_idx`.
  - On the accept with `wr_idx`=`general_input_dim`-1: `wr_idx`←0, go to RESET_ENG.
- **RESET_ENG**
  - `eng_reset`=1, `s_ready`=0.
  - Stays for `reset_cycles` cycles, then goes to SETTLE.
- **SETTLE**
  - `eng_reset`=0, `eng_data_valid`=0, for exactly 1 cycle.
  - This gives the engine's falling-edge reset logic a clean cycle. Then go to RUN.
  - Clear the timeout counter on entry to RUN.
- **RUN**
  - `eng_data_valid`=1. `eng_input` stays stable for the whole state.
  - If `eng_finish`=1: capture `eng_output` into `out_reg`, set `r_timeout`←0, go to ARGMAX.
  - Else, if the counter equals `timeout_cycles`-1: capture `eng_output` anyway, set `r_timeout`←1, go to ARGMAX.
  - Otherwise increment the counter.
- **ARGMAX**
  - `eng_data_valid`=0. Processes one element per cycle, `output_dim` cycles in total.
  - Cycle 0 loads `best`←element 0, `best_idx`←0.
  - Cycle k (k≥1): if element k > `best` (signed compare), replace `best` and `best_idx`.
  - Ties keep the lowest index.
  - After the last element: `r_class`←`best_idx`, `r_score`←`best`, go to RESULT.
- **RESULT**
  - `r_valid`=1; `r_class`, `r_score` and `r_timeout` are held stable.
  - On `r_valid`&`r_ready`: `sample_count`++, go to LOAD. Entering LOAD raises `eng_reset` again, which is the next posedge for the engine.
- The engine's `eng_finish` does not fall until it is reset, so every sample must pass through RESET_ENG. The engine is never relaunched without a reset.

## Timing
- **Reset (async)**
  - state=LOAD, `eng_reset`=1, `s_ready`=1, `eng_data_valid`=0.
  - `r_valid`=0, `r_class`=0, `r_score`=0, `r_timeout`=0, `sample_count`=0.
  - `eng_input`=0, `wr_idx`=0, counters=0.
- **Reset mid-operation:** all state is lost. A partially loaded sample is discarded. `eng_reset` rises immediately, so the engine is aborted.
- **Latency, last input accept to `r_valid`:** `reset_cycles` + 1 (SETTLE) + N_run + `output_dim` + 1 cycles. N_run is the number of RUN cycles, including the cycle in which `eng_finish` is sampled.
- **Input handshake**
  - Transfer occurs when `s_valid` and `s_ready` are both high at the clock edge.
  - `s_valid` may toggle freely; bubbles are allowed.
  - `s_ready` drops on the cycle after the final word is accepted.
- **Result handshake**
  - `r_valid` stays high until accepted and never drops without acceptance.
  - If `r_ready` is already high when `r_valid` rises, the transfer completes in 1 cycle.
  - LOAD (`s_ready`=1) starts the next cycle.
- **`eng_finish` already high on entry to RUN** (stale level): the capture still occurs in the first RUN cycle. RESET_ENG must have cleared it; the bench checks that it does.
- **Width:** all scores are signed two's complement `bitlength`. The engine saturates at +0x7FF, so a saturated score compares as the maximum.

## Test plan
- Reset, stream 15 words 0x001..0x00F with `s_valid` held high; engine model asserts finish 10 RUN cycles later with output {0x050, 0x120} → `r_class`=1, `r_score`=0x120, `r_timeout`=0, `eng_input` element 14 = 0x00F.
- Output {0xF00 (−256), 0xE00 (−512)} → `r_class`=0, `r_score`=0xF00 (signed compare check). Tie {0x7FF, 0x7FF} → `r_class`=0.
- `s_valid` toggling every other cycle → exactly 15 words captured in order; `eng_reset` high from reset through LOAD plus `reset_cycles`=2 cycles, followed by a 1-cycle SETTLE low before `eng_data_valid` rises.
- `timeout_cycles`=8, engine never finishes → `r_valid` after 8 RUN cycles with `r_timeout`=1 and `eng_output` captured as-is.
- `r_ready` held low for 20 cycles → `r_valid`, `r_class` and `r_score` stay stable and `sample_count` is unchanged; after acceptance, `sample_count`=1 and the second sample runs with a new `eng_reset` rising edge.
- Assert `reset` in the middle of RUN → outputs return to reset values asynchronously, `eng_reset`=1, and the next full sample produces a correct result.
